// File: rtl/hazard_check_pkg.sv
// Shared core definitions for the hazard check stage: opcode constants, the
// pending-counter width default, the check-register layout and source/dest decode.
package hazard_check_pkg;

  localparam int PEND_W_DEFAULT = 2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } check_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM,
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // x0 is never tracked, so a zero rd never counts as a write.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    return (opcode != OPC_STORE) && (opcode != OPC_BRANCH) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters with one increment port, two decrement
// ports (retire and flush) and busy/saturated lookups for rs1, rs2 and rd.
module hazard_scoreboard
  import hazard_check_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       inc_en,
  input  logic [4:0] inc_idx,
  input  logic       dec_a_en,
  input  logic [4:0] dec_a_idx,
  input  logic       dec_b_en,
  input  logic [4:0] dec_b_idx,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] rs2_idx,
  input  logic [4:0] rd_idx,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_sat,
  output logic       any_busy
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q [32];
  logic [PEND_W-1:0] cnt_d [32];

  // Increment first, then each decrement floors at zero: inc+dec on one
  // register nets to no change, and a double decrement of 1 lands on 0.
  // Increments never overflow because a saturated rd stalls issue.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cnt_d[r] = cnt_q[r];
      if (inc_en && inc_idx == 5'(r))
        cnt_d[r] = cnt_d[r] + PEND_W'(1);
      if (dec_a_en && dec_a_idx == 5'(r) && cnt_d[r] != '0)
        cnt_d[r] = cnt_d[r] - PEND_W'(1);
      if (dec_b_en && dec_b_idx == 5'(r) && cnt_d[r] != '0)
        cnt_d[r] = cnt_d[r] - PEND_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < 32; r++) begin
      // NOTE: this array is state, not storage -- it must be reset, otherwise a stale count stalls forever.
      if (RST) cnt_q[r] <= '0;
      // NOTE: sequential state uses non-blocking assignment only.
      else     cnt_q[r] <= cnt_d[r];
    end
  end

  assign rs1_busy = (cnt_q[rs1_idx] != '0);
  assign rs2_busy = (cnt_q[rs2_idx] != '0);
  assign rd_sat   = (cnt_q[rd_idx] == CNT_MAX);

  always_comb begin
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++)
      if (cnt_q[r] != '0) any_busy = 1'b1;
  end

endmodule

// File: rtl/hazard_check.sv
// Decode-2nd/check stage: check register, opcode decode and RAW/WAW stall.
// Build option HAZARD_CHECK_CSR_EN serialises SYSTEM instructions.
module hazard_check
  import hazard_check_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic        DECODE_VALID,
  input  logic [31:0] DECODE_PC,
  input  logic [6:0]  DECODE_OPCODE,
  input  logic [4:0]  DECODE_RS1,
  input  logic [4:0]  DECODE_RS2,
  input  logic [4:0]  DECODE_RD,
  input  logic [11:0] DECODE_CSR,
  input  logic [2:0]  DECODE_FUNCT3,
  input  logic [6:0]  DECODE_FUNCT7,
  input  logic [31:0] DECODE_IMM,
  input  logic        RETIRE_VALID,
  input  logic [4:0]  RETIRE_RD,
  output logic        STALL,
  output logic [31:0] CHECK_PC,
  output logic [6:0]  CHECK_OPCODE,
  output logic [4:0]  CHECK_RD,
  output logic [11:0] CHECK_CSR,
  output logic [2:0]  CHECK_FUNCT3,
  output logic [6:0]  CHECK_FUNCT7,
  output logic [31:0] CHECK_IMM
);

  check_t chk_q, chk_d;
  logic   dec_rs1, dec_rs2, dec_wr;
  logic   rs1_busy, rs2_busy, rd_sat, any_busy;
  logic   stall, issue;

  assign dec_rs1 = uses_rs1(DECODE_OPCODE);
  assign dec_rs2 = uses_rs2(DECODE_OPCODE);
  assign dec_wr  = writes_rd(DECODE_OPCODE, DECODE_RD);

  always_comb begin
    stall = 1'b0;
    if (DECODE_VALID) begin
      stall = (dec_rs1 && rs1_busy) || (dec_rs2 && rs2_busy) || (dec_wr && rd_sat);
`ifdef HAZARD_CHECK_CSR_EN
      if (DECODE_OPCODE == OPC_SYSTEM && any_busy) stall = 1'b1;
      if (chk_q.opcode == OPC_SYSTEM)              stall = 1'b1;
`endif
    end
  end

`ifndef HAZARD_CHECK_CSR_EN
  logic unused_any_busy;
  assign unused_any_busy = any_busy;
`endif

  assign STALL = stall;
  assign issue = DECODE_VALID && !stall && !MEM_WAIT && !FLUSH;

  // FLUSH beats MEM_WAIT; a stall or empty decode slot inserts a NOP.
  always_comb begin
    chk_d = chk_q;
    if (FLUSH) begin
      chk_d = '0;
    end else if (!MEM_WAIT) begin
      chk_d = '0;
      if (issue) begin
        chk_d.pc     = DECODE_PC;
        chk_d.opcode = DECODE_OPCODE;
        chk_d.rd     = DECODE_RD;
        chk_d.csr    = DECODE_CSR;
        chk_d.funct3 = DECODE_FUNCT3;
        chk_d.funct7 = DECODE_FUNCT7;
        chk_d.imm    = DECODE_IMM;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  hazard_scoreboard #(.PEND_W(PEND_W)) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .inc_en   (issue && dec_wr),
    .inc_idx  (DECODE_RD),
    .dec_a_en (RETIRE_VALID && RETIRE_RD != 5'd0),
    .dec_a_idx(RETIRE_RD),
    .dec_b_en (FLUSH && writes_rd(chk_q.opcode, chk_q.rd)),
    .dec_b_idx(chk_q.rd),
    .rs1_idx  (DECODE_RS1),
    .rs2_idx  (DECODE_RS2),
    .rd_idx   (DECODE_RD),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_sat   (rd_sat),
    .any_busy (any_busy)
  );

  assign CHECK_PC     = chk_q.pc;
  assign CHECK_OPCODE = chk_q.opcode;
  assign CHECK_RD     = chk_q.rd;
  assign CHECK_CSR    = chk_q.csr;
  assign CHECK_FUNCT3 = chk_q.funct3;
  assign CHECK_FUNCT7 = chk_q.funct7;
  assign CHECK_IMM    = chk_q.imm;

endmodule

// File: tb/tb_hazard_check.sv
// Scoreboard bench for hazard_check: directed scenarios then random traffic,
// checked against an abstract model of pending writes and the check register.
module tb_hazard_check;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [11:0] csr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } exp_t;

  localparam int PEND_MAX = 3;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, MEM_WAIT, DECODE_VALID, RETIRE_VALID;
  logic [31:0] DECODE_PC, DECODE_IMM;
  logic [6:0]  DECODE_OPCODE, DECODE_FUNCT7;
  logic [4:0]  DECODE_RS1, DECODE_RS2, DECODE_RD, RETIRE_RD;
  logic [11:0] DECODE_CSR;
  logic [2:0]  DECODE_FUNCT3;
  logic        STALL;
  logic [31:0] CHECK_PC, CHECK_IMM;
  logic [6:0]  CHECK_OPCODE, CHECK_FUNCT7;
  logic [4:0]  CHECK_RD;
  logic [11:0] CHECK_CSR;
  logic [2:0]  CHECK_FUNCT3;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   pend[32];
  exp_t mchk;

  always #5 CLK = ~CLK;

  hazard_check dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .DECODE_VALID(DECODE_VALID), .DECODE_PC(DECODE_PC), .DECODE_OPCODE(DECODE_OPCODE),
    .DECODE_RS1(DECODE_RS1), .DECODE_RS2(DECODE_RS2), .DECODE_RD(DECODE_RD),
    .DECODE_CSR(DECODE_CSR), .DECODE_FUNCT3(DECODE_FUNCT3), .DECODE_FUNCT7(DECODE_FUNCT7),
    .DECODE_IMM(DECODE_IMM), .RETIRE_VALID(RETIRE_VALID), .RETIRE_RD(RETIRE_RD),
    .STALL(STALL), .CHECK_PC(CHECK_PC), .CHECK_OPCODE(CHECK_OPCODE), .CHECK_RD(CHECK_RD),
    .CHECK_CSR(CHECK_CSR), .CHECK_FUNCT3(CHECK_FUNCT3), .CHECK_FUNCT7(CHECK_FUNCT7),
    .CHECK_IMM(CHECK_IMM)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Source/destination rules taken straight from the opcode table.
  function automatic bit m_src1(input logic [6:0] op);
    return op inside {7'h67, 7'h03, 7'h13, 7'h73, 7'h33, 7'h23, 7'h63};
  endfunction
  function automatic bit m_src2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction
  function automatic bit m_writes(input logic [6:0] op, input logic [4:0] rd);
    return !(op inside {7'h23, 7'h63}) && rd != 0;
  endfunction

  function automatic bit model_stall(input bit dv, input logic [6:0] op,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    bit s = 0;
    if (!dv) return 0;
    if (m_src1(op) && pend[rs1] != 0) s = 1;
    if (m_src2(op) && pend[rs2] != 0) s = 1;
    if (m_writes(op, rd) && pend[rd] == PEND_MAX) s = 1;
`ifdef HAZARD_CHECK_CSR_EN
    if (op == 7'h73) foreach (pend[r]) if (pend[r] != 0) s = 1;
    if (mchk.opcode == 7'h73) s = 1;
`endif
    return s;
  endfunction

  function automatic void m_dec(input logic [4:0] r);
    if (r != 0 && pend[r] > 0) pend[r]--;
  endfunction

  // One clock: drive at negedge, check STALL, advance model, queue expected CHECK_*.
  task automatic step(input bit rst, input bit flush, input bit mw, input bit dv,
                      input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm,
                      input bit rv, input logic [4:0] rrd);
    bit s;
    @(negedge CLK);
    RST = rst; FLUSH = flush; MEM_WAIT = mw; DECODE_VALID = dv;
    DECODE_OPCODE = op; DECODE_RS1 = rs1; DECODE_RS2 = rs2; DECODE_RD = rd;
    DECODE_IMM = imm; DECODE_PC = $urandom; DECODE_CSR = 12'($urandom);
    DECODE_FUNCT3 = 3'($urandom); DECODE_FUNCT7 = 7'($urandom);
    RETIRE_VALID = rv; RETIRE_RD = rrd;
    #1;
    s = model_stall(dv, op, rs1, rs2, rd);
    check("stall", 128'(STALL), 128'(s));
    if (rst) begin
      foreach (pend[r]) pend[r] = 0;
      mchk = '0;
    end else if (flush) begin
      if (m_writes(mchk.opcode, mchk.rd)) m_dec(mchk.rd);
      if (rv) m_dec(rrd);
      mchk = '0;
    end else begin
      if (!mw) begin
        if (dv && !s) begin
          if (m_writes(op, rd)) pend[rd]++;
          mchk.pc = DECODE_PC; mchk.opcode = op; mchk.rd = rd; mchk.csr = DECODE_CSR;
          mchk.funct3 = DECODE_FUNCT3; mchk.funct7 = DECODE_FUNCT7; mchk.imm = imm;
        end else begin
          mchk = '0;
        end
      end
      if (rv) m_dec(rrd);
    end
    exp_q.push_back(mchk);
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rv, input logic [4:0] rrd);
    step(0, 0, 0, 1, op, rs1, rs2, rd, 32'(rd) + 32'h100, rv, rrd);
  endtask

  task automatic retire(input logic [4:0] rrd);
    step(0, 0, 0, 0, 7'h00, 0, 0, 0, 0, 1, rrd);
  endtask

  // Monitor: the check register presents a new value every clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("check_reg",
              128'({CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_CSR, CHECK_FUNCT3, CHECK_FUNCT7, CHECK_IMM}),
              128'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [12];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h33, 7'h23, 7'h63, 7'h00, 7'h0F};
    RST = 1; FLUSH = 0; MEM_WAIT = 0; DECODE_VALID = 0; RETIRE_VALID = 0;
    DECODE_OPCODE = 0; DECODE_RS1 = 0; DECODE_RS2 = 0; DECODE_RD = 0; RETIRE_RD = 0;
    DECODE_PC = 0; DECODE_IMM = 0; DECODE_CSR = 0; DECODE_FUNCT3 = 0; DECODE_FUNCT7 = 0;
    foreach (pend[r]) pend[r] = 0;
    mchk = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ADDI x5,x0,1 then RAW on x5
    step(0, 0, 0, 1, 7'h13, 0, 0, 5, 32'd1, 0, 0);
    issue(7'h33, 5, 5, 6, 0, 0);
    issue(7'h33, 5, 5, 6, 1, 5);
    issue(7'h33, 5, 5, 6, 0, 0);
    retire(6);

    // saturation on x7
    issue(7'h37, 0, 0, 7, 0, 0);
    issue(7'h37, 0, 0, 7, 0, 0);
    issue(7'h37, 0, 0, 7, 0, 0);
    issue(7'h37, 0, 0, 7, 0, 0);
    issue(7'h37, 0, 0, 7, 1, 7);
    issue(7'h37, 0, 0, 7, 0, 0);
    issue(7'h33, 7, 0, 1, 0, 0);
    retire(7); retire(7); retire(7);
    issue(7'h33, 7, 0, 1, 0, 0);
    retire(1);

    // simultaneous inc/dec on x8, underflow on x9
    issue(7'h37, 0, 0, 8, 0, 0);
    issue(7'h37, 0, 0, 8, 1, 8);
    issue(7'h33, 8, 0, 2, 0, 0);
    retire(8);
    issue(7'h33, 8, 0, 2, 0, 0);
    retire(2);
    retire(9);
    issue(7'h13, 9, 0, 4, 0, 0);
    retire(4);

    // FLUSH squashes the write to x10 (and a retire of x10 the same cycle is floored)
    issue(7'h37, 0, 0, 10, 0, 0);
    step(0, 1, 0, 1, 7'h33, 10, 0, 11, 0, 1, 10);
    issue(7'h33, 10, 0, 11, 0, 0);
    retire(11);

    // MEM_WAIT hold with retirement applied
    issue(7'h37, 0, 0, 12, 0, 0);
    step(0, 0, 1, 1, 7'h37, 0, 0, 13, 0, 1, 12);
    step(0, 0, 1, 1, 7'h37, 0, 0, 13, 0, 0, 0);
    step(0, 0, 1, 0, 7'h00, 0, 0, 0, 0, 0, 0);
    issue(7'h33, 12, 0, 13, 0, 0);
    retire(13);

    // SYSTEM with an unrelated pending write to x3
    issue(7'h37, 0, 0, 3, 0, 0);
    issue(7'h73, 2, 0, 1, 0, 0);
    issue(7'h73, 2, 0, 1, 1, 3);
    issue(7'h73, 2, 0, 1, 0, 0);
    issue(7'h13, 0, 0, 14, 0, 0);
    issue(7'h13, 0, 0, 14, 0, 0);

    // random traffic on a small register window to provoke hazards
    for (int i = 0; i < 4000; i++) begin
      bit rst_r, fl_r, mw_r, dv_r, rv_r;
      rst_r = ($urandom_range(0, 199) == 0);
      fl_r  = ($urandom_range(0, 19) == 0);
      mw_r  = ($urandom_range(0, 9) == 0);
      dv_r  = ($urandom_range(0, 9) < 8);
      rv_r  = ($urandom_range(0, 9) < 4);
      step(rst_r, fl_r, mw_r, dv_r, ops[$urandom_range(0, 11)],
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom, rv_r, 5'($urandom_range(0, 7)));
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #2;
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_check.md
# hazard_check

Decode-2nd/check stage of the core pipeline: registers each decoded instruction into the check register that drives the `CHECK_*` bus consumed by the first scheduling stage. It also keeps a per-register scoreboard of in-flight destination writes. It raises `STALL` on RAW/WAW hazards, so the decoder and the scheduling stage hold while the hazard persists.

## Interface
Parameters:
- `PEND_W`, 2: width of each per-register pending-write counter (max in-flight writes per register = 2^PEND_W − 1).

Ports:
- `CLK` in 1: clock. One clock domain; all state changes on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `FLUSH` in 1: squash the check register.
- `MEM_WAIT` in 1: global memory hold.
- `DECODE_VALID` in 1: decoder presents an instruction.
- `DECODE_PC` in 32; `DECODE_OPCODE` in 7; `DECODE_RS1` / `DECODE_RS2` / `DECODE_RD` in 5; `DECODE_CSR` in 12; `DECODE_FUNCT3` in 3; `DECODE_FUNCT7` in 7; `DECODE_IMM` in 32: decoded fields.
- `RETIRE_VALID` in 1 / `RETIRE_RD` in 5: one downstream instruction leaves the window, either written back or squashed.
- `STALL` out 1: hazard hold to the decoder and scheduling stages.
- `CHECK_PC` out 32, `CHECK_OPCODE` out 7, `CHECK_RD` out 5, `CHECK_CSR` out 12, `CHECK_FUNCT3` out 3, `CHECK_FUNCT7` out 7, `CHECK_IMM` out 32: check register contents.

## Operation
- **Source use by opcode:**
  - LUI 0x37, AUIPC 0x17, JAL 0x6F: no sources.
  - JALR 0x67, LOAD 0x03, OP-IMM 0x13, SYSTEM 0x73: rs1 only.
  - OP 0x33, STORE 0x23, BRANCH 0x63: rs1 and rs2.
  - Any other opcode: no sources.
- **Writes rd:** every opcode except STORE and BRANCH, and only when rd ≠ 0. x0 is never tracked.
- **Hazard:** `STALL` = `DECODE_VALID` AND any of:
  - a used source has a nonzero pending count;
  - the rd pending count is saturated at 2^PEND_W − 1.
- **`STALL` timing:** combinational from the current decoder inputs and the scoreboard state.
- **Issue:** occurs when `DECODE_VALID` is high and `STALL`, `MEM_WAIT`, `FLUSH` are all low.
  - The check register loads the `DECODE_*` fields.
  - pending[rd] increments if the instruction writes rd.
- **Bubble:** when `STALL` is high or `DECODE_VALID` is low (with `MEM_WAIT` and `FLUSH` low), the check register loads all-zero fields (opcode 0 = NOP).
- **Hold:** while `MEM_WAIT` is high, the check register holds its contents and no increments occur. Retirements are still applied.
- **Retire:** `RETIRE_VALID` with `RETIRE_RD` ≠ 0 decrements pending[`RETIRE_RD`].
  - A decrement when the count is already 0 is ignored; the count stays 0.
- **Simultaneous increment and decrement of the same register:** the count is unchanged.
- **FLUSH** (FLUSH has priority over `MEM_WAIT`):
  - The check register clears to zero.
  - If the cleared entry writes rd, its count decrements. This and any same-cycle retirement to the same register both apply (net −2 when both hit one register).
  - Entries beyond the check register are reported squashed by downstream through `RETIRE_*`.
- **RST:** all counters = 0 and all `CHECK_*` = 0. Combinationally, `STALL` therefore equals 0 as well.

## Timing
- Latency from decoder to `CHECK_*`: 1 cycle.
- `STALL` reacts in the same cycle as the inputs change. A retirement that clears the last pending write lifts `STALL` in the cycle after `RETIRE_VALID`.
- Back-to-back retirements: one per cycle.
- Reset mid-operation discards all scoreboard state in one cycle.

## Configuration
- `HAZARD_CHECK_CSR_EN` defined:
  - SYSTEM opcode (0x73) instructions additionally stall until every pending counter is 0. This serialises CSR accesses.
  - A SYSTEM instruction in the check register also stalls the next decoded instruction for one cycle.
- Undefined: SYSTEM instructions obey only the normal rs1/rd rules.

## Structure
- Shared core package holds:
  - the opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM);
  - the `PEND_W` default.
- Sub-module `hazard_scoreboard` contains:
  - the 32×`PEND_W` counter array;
  - the increment/decrement ports;
  - per-register busy and saturated lookups (2 read ports for sources + 1 for rd).
- Top level holds the check register, opcode decode and stall logic.

## Test plan
- **Reset then simple issue.** After `RST`, issue ADDI x5,x0,1 (opcode 0x13, rd 5, imm 1). Next cycle `CHECK_RD` = 5 and `CHECK_IMM` = 1. `STALL` stays 0. pending[5] = 1.
- **RAW stall.** Issue ADD x6,x5,x5 with pending[5] = 1. `STALL` = 1 and the check register is a NOP. Pulse `RETIRE_RD` = 5. In the following cycle `STALL` = 0, then `CHECK_RD` = 6.
- **Saturation.** Issue three writes to x7 with no retirements. pending[7] = 3 and the fourth write to x7 stalls. One retirement of x7 releases it.
- **Simultaneous and underflow cases.**
  - Issue a write to x8 while retiring x8 with pending[8] = 1: pending[8] stays 1.
  - Retire x9 with pending[9] = 0: pending[9] stays 0.
- **FLUSH and MEM_WAIT.**
  - With `CHECK_RD` = 10 (pending[10] = 1), assert `FLUSH`: `CHECK_*` = 0 and pending[10] = 0.
  - With `MEM_WAIT` held 3 cycles: `CHECK_*` is unchanged and retirements still decrement counts.
- **`HAZARD_CHECK_CSR_EN`.** Issue CSRRW x1 (0x73) with pending[3] = 1. Defined: `STALL` until x3 retires. Undefined: issues immediately.
